// File: rtl/comparador_serial.sv
// Serial magnitude comparator: walks ANCHO-bit operands one ANCHO_DIG-bit segment
// per clock from the MSB end, stops on the first difference, and falls back to the cascade inputs.
module comparador_serial #(
  parameter int ANCHO     = 32,
  parameter int ANCHO_DIG = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inicio,
  input  logic             con_signo,
  input  logic [ANCHO-1:0] a,
  input  logic [ANCHO-1:0] b,
  input  logic             igual_i,
  input  logic             mayor_i,
  input  logic             menor_i,
  output logic             ocupado,
  output logic             listo,
  output logic             igual_o,
  output logic             mayor_o,
  output logic             menor_o
);

  localparam int NUM_SEG = (ANCHO / ANCHO_DIG < 1) ? 1 : ANCHO / ANCHO_DIG;
  localparam int IDX_W   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
  localparam logic [ANCHO_DIG-1:0] MSB_MASK = ANCHO_DIG'(1) << (ANCHO_DIG - 1);

  localparam logic [1:0] REPOSO  = 2'd0;
  localparam logic [1:0] COMPARA = 2'd1;
  localparam logic [1:0] FIN     = 2'd2;

  logic [1:0]           estado;
  logic [ANCHO-1:0]     a_r, b_r;
  logic                 signo_r, igual_r, mayor_r, menor_r;
  logic [IDX_W-1:0]     idx;
  logic [ANCHO_DIG-1:0] seg_a, seg_b;
  logic                 voltear, ultimo;

  // Operands shift left each step, so the segment under test is always the top one.
  // Flipping the sign bit turns a signed top-segment compare into an unsigned one.
  always_comb begin
    voltear = signo_r && (idx == IDX_W'(NUM_SEG - 1));
    seg_a   = a_r[ANCHO-1 -: ANCHO_DIG] ^ (voltear ? MSB_MASK : '0);
    seg_b   = b_r[ANCHO-1 -: ANCHO_DIG] ^ (voltear ? MSB_MASK : '0);
    ultimo  = (idx == '0);
  end

  assign ocupado = (estado == COMPARA);
  assign listo   = (estado == FIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado  <= REPOSO;
      a_r     <= '0;
      b_r     <= '0;
      signo_r <= 1'b0;
      igual_r <= 1'b0;
      mayor_r <= 1'b0;
      menor_r <= 1'b0;
      idx     <= '0;
      igual_o <= 1'b0;
      mayor_o <= 1'b0;
      menor_o <= 1'b0;
    end else begin
      case (estado)
        REPOSO: begin
          if (inicio) begin
            a_r     <= a;
            b_r     <= b;
            signo_r <= con_signo;
            igual_r <= igual_i;
            mayor_r <= mayor_i;
            menor_r <= menor_i;
            idx     <= IDX_W'(NUM_SEG - 1);
            estado  <= COMPARA;
          end
        end
        COMPARA: begin
          if (seg_a != seg_b) begin
            igual_o <= 1'b0;
            mayor_o <= (seg_a > seg_b);
            menor_o <= (seg_a < seg_b);
            estado  <= FIN;
          end else if (ultimo) begin
            // Fully equal operands: the lower-order stage decides, equal wins ties.
            if (igual_r) begin
              {igual_o, mayor_o, menor_o} <= 3'b100;
            end else if (mayor_r) begin
              {igual_o, mayor_o, menor_o} <= 3'b010;
            end else if (menor_r) begin
              {igual_o, mayor_o, menor_o} <= 3'b001;
            end else begin
              {igual_o, mayor_o, menor_o} <= 3'b100;
            end
            estado <= FIN;
          end else begin
            idx <= idx - IDX_W'(1);
            a_r <= a_r << ANCHO_DIG;
            b_r <= b_r << ANCHO_DIG;
          end
        end
        FIN:     estado <= REPOSO;
        default: estado <= REPOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_comparador_serial.sv
// Scoreboard bench for comparador_serial: a 32/8 instance and an 8/8 instance,
// directed vectors push expected results, per-instance monitors pop on listo.
module tb_comparador_serial;

  typedef struct {
    logic [2:0] res;
    int         cyc;
    string      name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inicio = 1'b0, inicio_s = 1'b0;
  logic        con_signo = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [7:0]  a_s = '0, b_s = '0;
  logic        igual_i = 1'b0, mayor_i = 1'b0, menor_i = 1'b0;
  logic        ocupado, listo, igual_o, mayor_o, menor_o;
  logic        ocupado_s, listo_s, igual_s, mayor_s, menor_s;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q_w[$];
  exp_t q_s[$];

  comparador_serial #(.ANCHO(32), .ANCHO_DIG(8)) dut (
    .clk(clk), .reset(reset), .inicio(inicio), .con_signo(con_signo),
    .a(a), .b(b), .igual_i(igual_i), .mayor_i(mayor_i), .menor_i(menor_i),
    .ocupado(ocupado), .listo(listo),
    .igual_o(igual_o), .mayor_o(mayor_o), .menor_o(menor_o)
  );

  comparador_serial #(.ANCHO(8), .ANCHO_DIG(8)) dut_s (
    .clk(clk), .reset(reset), .inicio(inicio_s), .con_signo(con_signo),
    .a(a_s), .b(b_s), .igual_i(igual_i), .mayor_i(mayor_i), .menor_i(menor_i),
    .ocupado(ocupado_s), .listo(listo_s),
    .igual_o(igual_s), .mayor_o(mayor_s), .menor_o(menor_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pops the oldest expectation of the selected instance and checks result and latency.
  task automatic checkOutput(input bit sel, input logic [2:0] got);
    exp_t e;
    if (sel ? (q_s.size() == 0) : (q_w.size() == 0)) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_listo dut=%0d got=%b cycle=%0d", sel, got, cyc);
    end else begin
      e = sel ? q_s.pop_front() : q_w.pop_front();
      checks++;
      if (got !== e.res) begin
        errors++;
        $display("[TB] FAIL %s result {igual,mayor,menor} got=%b expected=%b", e.name, got, e.res);
      end
      checks++;
      if (cyc != e.cyc) begin
        errors++;
        $display("[TB] FAIL %s latency listo_cycle got=%0d expected=%0d", e.name, cyc, e.cyc);
      end
    end
  endtask

  always @(negedge clk) if (!reset && listo)   checkOutput(1'b0, {igual_o, mayor_o, menor_o});
  always @(negedge clk) if (!reset && listo_s) checkOutput(1'b1, {igual_s, mayor_s, menor_s});

  // Issues one operation, scrambles the inputs right after capture and waits for the scoreboard to drain.
  task automatic applyStimulus(input bit sel, input logic [31:0] av, input logic [31:0] bv,
                               input logic sg, input logic ig, input logic ma, input logic me,
                               input logic [2:0] res, input int k, input bit glitch, input string nm);
    exp_t e;
    int   n;
    n = 0;
    while ((sel ? (ocupado_s || listo_s) : (ocupado || listo)) && n < 50) begin
      @(negedge clk);
      n++;
    end
    e.res  = res;
    e.cyc  = cyc + 1 + k;
    e.name = nm;
    if (sel) begin
      q_s.push_back(e);
      a_s = av[7:0];
      b_s = bv[7:0];
      inicio_s = 1'b1;
    end else begin
      q_w.push_back(e);
      a = av;
      b = bv;
      inicio = 1'b1;
    end
    con_signo = sg;
    igual_i = ig;
    mayor_i = ma;
    menor_i = me;
    @(negedge clk);
    inicio    = glitch && !sel;
    inicio_s  = 1'b0;
    a         = ~av;
    b         = bv ^ 32'h8000_0001;
    a_s       = ~av[7:0];
    b_s       = bv[7:0] ^ 8'h81;
    con_signo = ~sg;
    igual_i   = ~ig;
    mayor_i   = ~ma;
    menor_i   = ~me;
    checks++;
    if ((sel ? ocupado_s : ocupado) !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s ocupado_after_accept got=%b expected=1", nm, sel ? ocupado_s : ocupado);
    end
    @(negedge clk);
    inicio = 1'b0;
    n = 0;
    while ((sel ? q_s.size() : q_w.size()) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if ((sel ? q_s.size() : q_w.size()) != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout listo got=none expected=pulse", nm);
      if (sel) q_s.delete(); else q_w.delete();
    end
  endtask

  initial begin
    #2;
    checks++;
    if ({ocupado, listo, igual_o, mayor_o, menor_o} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_state_w got=%b expected=00000", {ocupado, listo, igual_o, mayor_o, menor_o});
    end
    checks++;
    if ({ocupado_s, listo_s, igual_s, mayor_s, menor_s} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_state_s got=%b expected=00000", {ocupado_s, listo_s, igual_s, mayor_s, menor_s});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(0, 32'h1234_5678, 32'h1234_5678, 0, 1, 0, 0, 3'b100, 4, 0, "eq_full");
    applyStimulus(0, 32'h6400_0000, 32'h5500_0000, 0, 0, 0, 0, 3'b010, 1, 0, "early_gt");
    applyStimulus(0, 32'hFFFF_FFFA, 32'h0000_0005, 1, 0, 0, 0, 3'b001, 1, 0, "signed_neg_lt");
    applyStimulus(0, 32'hFFFF_FFFA, 32'h0000_0005, 0, 0, 0, 0, 3'b010, 1, 0, "unsigned_big_gt");
    applyStimulus(0, 32'hFFFF_FFFA, 32'hFFFF_FFFB, 1, 0, 0, 0, 3'b001, 4, 0, "signed_seg0_lt");
    applyStimulus(0, 32'h0000_0000, 32'h0000_0000, 0, 0, 1, 0, 3'b010, 4, 0, "cascade_mayor");
    applyStimulus(0, 32'h0000_0000, 32'h0000_0000, 0, 0, 0, 1, 3'b001, 4, 0, "cascade_menor");
    applyStimulus(0, 32'h0000_0000, 32'h0000_0000, 0, 0, 0, 0, 3'b100, 4, 0, "cascade_none");
    applyStimulus(0, 32'h0000_0000, 32'h0000_0000, 0, 1, 1, 1, 3'b100, 4, 0, "cascade_priority");
    applyStimulus(0, 32'h8000_0000, 32'h7FFF_FFFF, 1, 0, 0, 0, 3'b001, 1, 0, "signed_min_lt");
    applyStimulus(0, 32'h8000_0000, 32'h7FFF_FFFF, 0, 0, 0, 0, 3'b010, 1, 0, "unsigned_msb_gt");
    applyStimulus(0, 32'h1200_0034, 32'h1200_0035, 0, 0, 0, 0, 3'b001, 4, 1, "inicio_while_busy");
    applyStimulus(1, 32'd100, 32'd85, 0, 0, 0, 0, 3'b010, 1, 0, "narrow_gt");
    applyStimulus(1, 32'h80, 32'h01, 1, 0, 0, 0, 3'b001, 1, 0, "narrow_signed_lt");

    // Abort a running comparison in its second COMPARA cycle.
    a = 32'h0000_0001;
    b = 32'h0000_0002;
    con_signo = 1'b0;
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({ocupado, listo, igual_o, mayor_o, menor_o} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_abort got=%b expected=00000", {ocupado, listo, igual_o, mayor_o, menor_o});
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if ({ocupado, listo} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL post_abort_idle got=%b expected=00", {ocupado, listo});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/comparador_serial.md
Name: comparador_serial

Overview:
- Parametrised, cascadable magnitude comparator for wide operands; compares ANCHO-bit a and b one ANCHO_DIG-bit segment per clock, MSB segment first.
- Terminates early on the first differing segment.
- Supports unsigned or two's-complement signed mode per operation.
- Accepts igual/mayor/menor cascade inputs and uses them to resolve the result when a and b are fully equal.
- Intended as the multi-cycle, area-lean successor to the 8-bit combinational comparator for 16/32/64-bit datapaths.

Parameters:
ANCHO, 32, total operand width in bits; must be a multiple of ANCHO_DIG.
ANCHO_DIG, 8, segment width compared per clock; NUM_SEG = ANCHO/ANCHO_DIG, minimum 1.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
inicio  input  1  start request; sampled only when ocupado=0.
con_signo  input  1  1 = signed two's-complement compare, 0 = unsigned; captured with inicio.
a  input  ANCHO  operand A; captured with inicio.
b  input  ANCHO  operand B; captured with inicio.
igual_i  input  1  cascade in: lower-order stage reports equal.
mayor_i  input  1  cascade in: lower-order stage reports A>B.
menor_i  input  1  cascade in: lower-order stage reports A<B.
ocupado  output  1  high while a comparison is in progress.
listo  output  1  one-cycle pulse; result valid.
igual_o  output  1  result A==B (after cascade resolution).
mayor_o  output  1  result A>B.
menor_o  output  1  result A<B.

Behaviour:
Reset:
- While reset=1, asynchronously: ocupado=0, listo=0, igual_o=0, mayor_o=0, menor_o=0.
- State forced to REPOSO; internal operand, mode and cascade registers cleared.
- Reset mid-operation aborts the comparison with no listo pulse.

States:
- REPOSO:
  - ocupado=0.
  - On a clock edge with inicio=1: capture a, b, con_signo, igual_i, mayor_i, menor_i; segment index idx=NUM_SEG-1; go to COMPARA; ocupado=1 from the next cycle.
  - Outputs igual_o/mayor_o/menor_o keep their last result until the new result is written.
- COMPARA:
  - Each edge compares segment idx of the captured operands.
  - Top segment (idx=NUM_SEG-1) is compared signed when con_signo=1. All lower segments are always unsigned.
  - If the segments differ, write mayor_o/menor_o accordingly (exactly one high, igual_o=0) and go to FIN.
  - If the segments are equal and idx=0, resolve via the captured cascade inputs and go to FIN.
  - Otherwise decrement idx and stay in COMPARA.
- FIN:
  - listo=1 and ocupado=0 for exactly one cycle.
  - Next state is REPOSO.
  - inicio is ignored during FIN.

Cascade resolution (all segments equal), priority igual_i > mayor_i > menor_i:
- igual_i=1 -> igual_o=1.
- else mayor_i=1 -> mayor_o=1.
- else menor_i=1 -> menor_o=1.
- else (all low) -> igual_o=1.

Output and timing rules:
- Exactly one of igual_o/mayor_o/menor_o is high after any completed operation.
- Latency: if inicio is accepted at edge t and k segments are examined (1 ≤ k ≤ NUM_SEG), the result registers update at edge t+k. listo is high in the cycle after edge t+k.
- Throughput: a new inicio can be accepted at the first REPOSO edge after FIN.
- inicio while ocupado=1 or in FIN is ignored; no queuing.
- Input changes on a, b, con_signo or the cascade inputs after capture have no effect on the running operation.

Test Plan:
1. ANCHO=32/ANCHO_DIG=8, unsigned, a=b=0x12345678, igual_i=1 -> 4 COMPARA cycles; listo in cycle 5 after inicio; igual_o=1, mayor_o=0, menor_o=0.
2. Unsigned, a=0x64000000, b=0x55000000 -> early exit after 1 segment; listo in cycle 2; mayor_o=1.
3. a=0xFFFFFFFA, b=0x00000005, run twice:
   - con_signo=1 -> menor_o=1 (-6<5).
   - con_signo=0 -> mayor_o=1.
   - Both runs: listo in cycle 2.
4. a=0xFFFFFFFA, b=0xFFFFFFFB, con_signo=1 -> exits at segment 0 after 4 cycles; menor_o=1.
5. Cascade resolution with a=b=0x0000_0000:
   - igual_i=0, mayor_i=1 -> mayor_o=1.
   - Rerun with menor_i=1 only -> menor_o=1.
   - Rerun with all cascade inputs 0 -> igual_o=1.
6. Control hazards:
   - Pulse inicio again during ocupado with different operands -> ignored; first result is unchanged.
   - Assert reset on the 2nd COMPARA cycle -> ocupado/outputs go 0 immediately; no listo pulse.
   - With ANCHO=ANCHO_DIG=8, a=100, b=85 -> mayor_o=1; listo in cycle 2.
